// File: rtl/pea_instr_scheduler.sv
// pea_instr_scheduler: instruction sequencer for the polynomial evaluation
// accelerator. Pops one instruction, decodes it, starts the matching
// sub-FSM (STP/EVP/EVB) or pulses the instruction reset, then writes a
// result/status word pair to the output FIFO. One instruction in flight.
// Optional macro PEA_SCHED_WDOG_EN adds a WAIT_DONE watchdog that aborts the
// instruction with status 4 after TIMEOUT_CYCLES cycles without a done.
module pea_instr_scheduler #(
    parameter int INSTR_W        = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_pop,
    output logic               start_stp,
    output logic               start_evp,
    output logic               start_evb,
    input  logic               done_stp,
    input  logic               done_evp,
    input  logic               done_evb,
    input  logic [DATA_W-1:0]  res_stp,
    input  logic [DATA_W-1:0]  res_evp,
    input  logic [DATA_W-1:0]  res_evb,
    input  logic [DATA_W-1:0]  sts_stp,
    input  logic [DATA_W-1:0]  sts_evp,
    input  logic [DATA_W-1:0]  sts_evb,
    output logic [2:0]         A_out,
    output logic               rst_instr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic [15:0]        instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_DISPATCH, S_WAIT_DONE, S_RST_PULSE, S_WRITE_RES, S_WRITE_STS
    } state_t;

    localparam logic [3:0] OP_STP = 4'd0;
    localparam logic [3:0] OP_EVP = 4'd1;
    localparam logic [3:0] OP_EVB = 4'd2;
    localparam logic [3:0] OP_RST = 4'd3;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [2:0]          a_q, a_d;
    logic [2:0]          a_out_q, a_out_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   sts_q, sts_d;
    logic [15:0]         count_q, count_d;

    // argument field travels with the instruction but is not interpreted here
    logic unused_arg;
    assign unused_arg = ^instr[INSTR_W-1:7];

`ifdef PEA_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    // done/result/status of the sub-FSM selected by the current opcode
    logic              done_sel;
    logic [DATA_W-1:0] res_sel, sts_sel;

    // route the active sub-FSM's handshake; others are ignored
    always_comb begin
        done_sel = 1'b0;
        res_sel  = '0;
        sts_sel  = '0;
        case (op_q)
            OP_STP:  begin done_sel = done_stp; res_sel = res_stp; sts_sel = sts_stp; end
            OP_EVP:  begin done_sel = done_evp; res_sel = res_evp; sts_sel = sts_evp; end
            OP_EVB:  begin done_sel = done_evb; res_sel = res_evb; sts_sel = sts_evb; end
            default: ;
        endcase
    end

    // next-state and output decode
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        a_out_d   = a_out_q;
        res_d     = res_q;
        sts_d     = sts_q;
        count_d   = count_q;
        instr_pop = 1'b0;
        start_stp = 1'b0;
        start_evp = 1'b0;
        start_evb = 1'b0;
        rst_instr = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
`ifdef PEA_SCHED_WDOG_EN
        wd_cnt_d  = '0;
`endif
        case (state_q)
            S_IDLE: begin
                // never pop while reset is held so the FIFO head is not lost
                if (instr_valid && !rst) begin
                    instr_pop = 1'b1;
                    op_d      = instr[3:0];
                    a_d       = instr[6:4];
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                a_out_d = a_q;
                case (op_q)
                    OP_STP, OP_EVP, OP_EVB: state_d = S_DISPATCH;
                    OP_RST: begin
                        res_d   = '0;
                        sts_d   = '0;
                        state_d = S_RST_PULSE;
                    end
                    default: begin
                        res_d   = '0;
                        sts_d   = DATA_W'(3);
                        state_d = S_WRITE_RES;
                    end
                endcase
            end
            S_DISPATCH: begin
                start_stp = (op_q == OP_STP);
                start_evp = (op_q == OP_EVP);
                start_evb = (op_q == OP_EVB);
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_sel) begin
                    res_d   = res_sel;
                    sts_d   = sts_sel;
                    state_d = S_WRITE_RES;
                end
`ifdef PEA_SCHED_WDOG_EN
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // hung sub-FSM: reset it and report a timeout
                    res_d   = '0;
                    sts_d   = DATA_W'(4);
                    state_d = S_RST_PULSE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            S_RST_PULSE: begin
                rst_instr = 1'b0;
                state_d   = S_WRITE_RES;
            end
            S_WRITE_RES: begin
                out_valid = 1'b1;
                out_data  = res_q;
                if (out_ready) state_d = S_WRITE_STS;
            end
            S_WRITE_STS: begin
                out_valid = 1'b1;
                out_data  = sts_q;
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            a_out_q <= '0;
            res_q   <= '0;
            sts_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            a_out_q <= a_out_d;
            res_q   <= res_d;
            sts_q   <= sts_d;
            count_q <= count_d;
        end
    end

`ifdef PEA_SCHED_WDOG_EN
    // watchdog counter, only advances while waiting for done
    always_ff @(posedge clk) begin
        if (rst) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`endif

    assign A_out       = a_out_q;
    assign busy        = (state_q != S_IDLE);
    assign instr_count = count_q;

endmodule

// File: tb/tb_pea_instr_scheduler.sv
// Self-checking bench for pea_instr_scheduler: vector table of single
// instructions plus hand sequences for latency, output stall, mid-op reset
// and the watchdog. Expected output words go through a scoreboard queue.
module tb_pea_instr_scheduler;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 32;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               instr_valid, instr_pop;
    logic [INSTR_W-1:0] instr;
    logic               start_stp, start_evp, start_evb;
    logic               done_stp, done_evp, done_evb;
    logic [DATA_W-1:0]  res_stp, res_evp, res_evb, sts_stp, sts_evp, sts_evb;
    logic [2:0]         A_out;
    logic               rst_instr, out_valid, out_ready, busy;
    logic [DATA_W-1:0]  out_data;
    logic [15:0]        instr_count;

    pea_instr_scheduler #(.INSTR_W(INSTR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_pop(instr_pop),
        .start_stp(start_stp), .start_evp(start_evp), .start_evb(start_evb),
        .done_stp(done_stp), .done_evp(done_evp), .done_evb(done_evb),
        .res_stp(res_stp), .res_evp(res_evp), .res_evb(res_evb),
        .sts_stp(sts_stp), .sts_evp(sts_evp), .sts_evb(sts_evb),
        .A_out(A_out), .rst_instr(rst_instr), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .instr_count(instr_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- sub-FSM model ----------------
    int          mdl_delay = 1;   // cycles from start to done; 0 = never
    logic        mdl_stray = 1'b0;
    logic [31:0] mdl_res = '0, mdl_sts = '0;

    task automatic pulse_done(input int u);
        case (u)
            0: done_stp = 1'b1;
            1: done_evp = 1'b1;
            default: done_evb = 1'b1;
        endcase
    endtask

    initial begin
        int cnt, unit, stray_unit;
        logic stray_pend;
        cnt = 0; unit = 0; stray_unit = 0; stray_pend = 1'b0;
        done_stp = 0; done_evp = 0; done_evb = 0;
        res_stp = 32'hBAD0_0000; res_evp = 32'hBAD0_0001; res_evb = 32'hBAD0_0002;
        sts_stp = 32'hBAD1_0000; sts_evp = 32'hBAD1_0001; sts_evb = 32'hBAD1_0002;
        forever begin
            @(negedge clk);
            done_stp = 0; done_evp = 0; done_evb = 0;
            if (stray_pend) begin
                pulse_done(stray_unit);
                stray_pend = 1'b0;
            end
            if (start_stp || start_evp || start_evb) begin
                unit = start_evp ? 1 : (start_evb ? 2 : 0);
                res_stp = 32'hBAD0_0000; res_evp = 32'hBAD0_0001; res_evb = 32'hBAD0_0002;
                sts_stp = 32'hBAD1_0000; sts_evp = 32'hBAD1_0001; sts_evb = 32'hBAD1_0002;
                case (unit)
                    0: begin res_stp = mdl_res; sts_stp = mdl_sts; end
                    1: begin res_evp = mdl_res; sts_evp = mdl_sts; end
                    default: begin res_evb = mdl_res; sts_evb = mdl_sts; end
                endcase
                cnt = mdl_delay;
                if (mdl_stray) begin
                    stray_pend = 1'b1;
                    stray_unit = (unit + 1) % 3;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) pulse_done(unit);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] sb[$];
    int cyc = 0, n_pop = 0, n_stp = 0, n_evp = 0, n_evb = 0, n_rstl = 0, n_xfer = 0;
    int pop_cyc = 0, start_cyc = 0, rstl_cyc = 0, xfer_cyc = 0, xfer_prev_cyc = 0, idle_cyc = 0;
    logic [2:0] a_at_start = '0;

    initial begin
        logic prev_v, prev_r, prev_busy;
        logic [31:0] prev_d, e;
        int ns;
        prev_v = 0; prev_r = 0; prev_busy = 0; prev_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (instr_pop) begin
                n_pop++;
                pop_cyc = cyc;
                chk("pop_only_idle", {31'd0, busy}, 32'd0);
            end
            ns = int'(start_stp) + int'(start_evp) + int'(start_evb);
            if (ns != 0) begin
                chk("single_start", ns, 1);
                start_cyc  = cyc;
                a_at_start = A_out;
            end
            if (start_stp) n_stp++;
            if (start_evp) n_evp++;
            if (start_evb) n_evb++;
            if (!rst_instr) begin
                n_rstl++;
                rstl_cyc = cyc;
            end
            if (prev_v && !prev_r && !rst) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                xfer_prev_cyc = xfer_cyc;
                xfer_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_word", out_data, e);
                end
            end
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_busy = busy;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_pop();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            #2;
            if (instr_pop) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) fail_now("pop_wait");
    endtask

    task automatic present(input logic [15:0] w);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = w;
        wait_pop();
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        logic got;
        got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #2;
            if (!busy) begin got = 1'b1; break; end
        end
        if (!got) fail_now("idle_wait");
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  a;
        int          dly;
        logic        stray;
        logic [31:0] res, sts, e_res, e_sts;
        logic [2:0]  e_start;   // {evb, evp, stp}
        int          e_rst;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s_stp, s_evp, s_evb, s_rst, s_x, s_pop;
        logic [15:0] s_cnt;
        instr_valid = 0; instr = '0; out_ready = 1'b1;

        vecs[0] = '{4'd1, 3'd2, 3, 1'b0, 32'd57,        32'd0,        32'd57,        32'd0,        3'b010, 0};
        vecs[1] = '{4'd0, 3'd5, 1, 1'b0, 32'h11,        32'd1,        32'h11,        32'd1,        3'b001, 0};
        vecs[2] = '{4'd2, 3'd7, 2, 1'b1, 32'hCAFE,      32'd0,        32'hCAFE,      32'd0,        3'b100, 0};
        vecs[3] = '{4'd1, 3'd1, 4, 1'b1, 32'd0,         32'd2,        32'd0,         32'd2,        3'b010, 0};
        vecs[4] = '{4'd3, 3'd3, 1, 1'b0, 32'h77,        32'h77,       32'd0,         32'd0,        3'b000, 1};
        vecs[5] = '{4'hA, 3'd0, 1, 1'b0, 32'h77,        32'h77,       32'd0,         32'd3,        3'b000, 0};
        vecs[6] = '{4'hF, 3'd6, 1, 1'b0, 32'h77,        32'h77,       32'd0,         32'd3,        3'b000, 0};
        vecs[7] = '{4'd0, 3'd0, 1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 0};

        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_pop", {31'd0, instr_pop}, 0);
        chk("rst_start", {29'd0, start_evb, start_evp, start_stp}, 0);
        chk("rst_a_out", {29'd0, A_out}, 0);
        chk("rst_rst_instr", {31'd0, rst_instr}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_count", {16'd0, instr_count}, 0);
        rst = 1'b0;

        // table-driven single instructions
        for (int i = 0; i < 8; i++) begin
            mdl_delay = vecs[i].dly; mdl_stray = vecs[i].stray;
            mdl_res = vecs[i].res; mdl_sts = vecs[i].sts;
            s_stp = n_stp; s_evp = n_evp; s_evb = n_evb; s_rst = n_rstl; s_x = n_xfer;
            s_cnt = instr_count;
            sb.push_back(vecs[i].e_res);
            sb.push_back(vecs[i].e_sts);
            present({9'h1A5, vecs[i].a, vecs[i].op});
            wait_idle(100);
            chk($sformatf("v%0d_start_stp", i), n_stp - s_stp, {31'd0, vecs[i].e_start[0]});
            chk($sformatf("v%0d_start_evp", i), n_evp - s_evp, {31'd0, vecs[i].e_start[1]});
            chk($sformatf("v%0d_start_evb", i), n_evb - s_evb, {31'd0, vecs[i].e_start[2]});
            chk($sformatf("v%0d_rst_low", i), n_rstl - s_rst, vecs[i].e_rst);
            chk($sformatf("v%0d_words", i), n_xfer - s_x, 2);
            chk($sformatf("v%0d_count", i), {16'd0, instr_count}, {16'd0, s_cnt + 16'd1});
            chk($sformatf("v%0d_a_out", i), {29'd0, A_out}, {29'd0, vecs[i].a});
            if (vecs[i].e_start != 3'b000)
                chk($sformatf("v%0d_a_at_start", i), {29'd0, a_at_start}, {29'd0, vecs[i].a});
            chk($sformatf("v%0d_sb_empty", i), sb.size(), 0);
        end

        // minimum latency: EVP, done one cycle after start, ready high
        mdl_delay = 1; mdl_stray = 0; mdl_res = 32'h1234; mdl_sts = 32'h5;
        sb.push_back(32'h1234); sb.push_back(32'h5);
        present({9'h0, 3'd4, 4'd1});
        wait_idle(100);
        chk("lat_start", start_cyc - pop_cyc, 2);
        chk("lat_res", xfer_prev_cyc - pop_cyc, 4);
        chk("lat_sts", xfer_cyc - pop_cyc, 5);
        chk("lat_idle", idle_cyc - pop_cyc, 6);

        // EVP then STP queued behind it, result word stalled for 5 cycles
        mdl_delay = 2; mdl_res = 32'hAAAA_0001; mdl_sts = 32'h0;
        s_cnt = instr_count;
        sb.push_back(32'hAAAA_0001); sb.push_back(32'h0);
        out_ready = 1'b0;
        present({9'h0, 3'd2, 4'd1});
        instr_valid = 1'b1;
        instr = {9'h0, 3'd6, 4'd0};
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk); #2;
                if (out_valid) begin got = 1'b1; break; end
            end
            if (!got) fail_now("stall_valid_wait");
        end
        mdl_delay = 1; mdl_res = 32'h5555_0002; mdl_sts = 32'h1;
        sb.push_back(32'h5555_0002); sb.push_back(32'h1);
        s_pop = n_pop;
        repeat (5) @(negedge clk);
        #2;
        chk("stall_data", out_data, 32'hAAAA_0001);
        chk("stall_no_pop", n_pop - s_pop, 0);
        @(negedge clk);
        out_ready = 1'b1;
        wait_pop();
        chk("stall_pop_after_sts", {31'd0, (pop_cyc > xfer_cyc)}, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_idle(100);
        chk("stall_count", {16'd0, instr_count}, {16'd0, s_cnt + 16'd2});
        chk("stall_sb_empty", sb.size(), 0);

        // reset while waiting for done; the late done_evp must be ignored
        mdl_delay = 50;
        s_x = n_xfer;
        present({9'h0, 3'd1, 4'd1});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_out_valid", {31'd0, out_valid}, 0);
        chk("mrst_count", {16'd0, instr_count}, 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        #2;
        chk("mrst_still_idle", {31'd0, busy}, 0);
        chk("mrst_no_words", n_xfer - s_x, 0);

        // done never arrives
        mdl_delay = 0;
        s_rst = n_rstl;
`ifdef PEA_SCHED_WDOG_EN
        sb.push_back(32'h0); sb.push_back(32'h4);
        present({9'h0, 3'd3, 4'd1});
        wait_idle(200);
        chk("wdog_rst_delay", rstl_cyc - start_cyc, TMO + 1);
        chk("wdog_rst_low", n_rstl - s_rst, 1);
        chk("wdog_sb_empty", sb.size(), 0);
`else
        present({9'h0, 3'd3, 4'd1});
        repeat (100) @(negedge clk);
        #2;
        chk("nowdog_busy", {31'd0, busy}, 1);
        chk("nowdog_rst_low", n_rstl - s_rst, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pea_instr_scheduler.md
Name: pea_instr_scheduler

Overview:
Top-level instruction sequencer for the polynomial evaluation accelerator. It pops instruction words from the command FIFO, decodes them and starts exactly one sub-FSM at a time (store-polynomial STP, evaluate EVP, evaluate-block EVB). It also applies the instruction-level reset, waits for the sub-FSM's done pulse, and pushes a result/status word pair into the output FIFO.

Parameters:
INSTR_W, 16, instruction word width; bits [3:0] opcode, [6:4] A (polynomial slot), [15:7] argument (unused here, passed through)
DATA_W, 32, result/status word width
TIMEOUT_CYCLES, 4096, watchdog limit on WAIT_DONE (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  command FIFO not empty
instr  in  INSTR_W  head-of-FIFO instruction word
instr_pop  out  1  one-cycle pop of command FIFO
start_stp / start_evp / start_evb  out  1 each  one-cycle start pulse to the sub-FSM
done_stp / done_evp / done_evb  in  1 each  one-cycle done pulse from the sub-FSM
res_stp / res_evp / res_evb  in  DATA_W each  sub-FSM result, valid with its done
sts_stp / sts_evp / sts_evb  in  DATA_W each  sub-FSM status, valid with its done
A_out  out  3  registered A field, held stable from DISPATCH through WAIT_DONE
rst_instr  out  1  active-low instruction reset to the sub-FSMs, low for exactly 1 cycle on RST
out_valid  out  1  output word valid
out_data  out  DATA_W  output word
out_ready  in  1  output FIFO can accept
busy  out  1  high in every state except IDLE
instr_count  out  16  instructions retired, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values: instr_pop=0, all start_*=0, A_out=0, rst_instr=1, out_valid=0, out_data=0, busy=0, instr_count=0, state=IDLE. Reset mid-operation aborts immediately and issues no output words.
- Opcodes: 0 STP, 1 EVP, 2 EVB, 3 RST. Any other opcode is illegal.
- IDLE: when instr_valid=1, latch instr and assert instr_pop for that same cycle, then go to DECODE. Pops happen only from IDLE.
- DECODE (1 cycle): store A into A_out.
  - STP/EVP/EVB -> DISPATCH.
  - RST -> RST_PULSE.
  - Illegal -> WRITE_RES with result=0, status=32'h3.
- DISPATCH (1 cycle): assert the matching start_* for one cycle, then go to WAIT_DONE.
- WAIT_DONE: on the active op's done pulse, capture its res/sts into internal registers, then go to WRITE_RES.
  - done pulses from the other sub-FSMs are ignored.
  - A done arriving in the same cycle as its start is not possible. The earliest done is the cycle after DISPATCH and must be accepted.
- RST_PULSE (1 cycle): rst_instr=0, then go to WRITE_RES with result=0, status=0.
- WRITE_RES: out_valid=1, out_data=result; hold until out_ready=1, then go to WRITE_STS.
- WRITE_STS: out_valid=1, out_data=status; hold until out_ready=1, then increment instr_count and go to IDLE.
- Output handshake: out_data must stay stable while out_valid=1 and out_ready=0. A transfer occurs only on a cycle with valid&&ready.
- Minimum latency for EVP with done 1 cycle after start and out_ready tied high:
  - pop at cycle 0;
  - start at cycle 2;
  - result word at cycle 4;
  - status word at cycle 5;
  - back in IDLE at cycle 6.
- Back-to-back instructions: the next pop occurs no earlier than the cycle after IDLE is re-entered. There is never more than one instruction in flight.
- Sub-FSM status values are passed through unmodified (e.g. EVP error status 2 for N=31).

Optional Feature:
PEA_SCHED_WDOG_EN
- Defined: a counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES without a done pulse:
  - the block pulses rst_instr low for 1 cycle;
  - it emits result=0, status=32'h4 (WRITE_RES/WRITE_STS).
  - The counter clears on leaving WAIT_DONE.
- Not defined: no counter exists, and WAIT_DONE waits indefinitely.

Test Plan:
- EVP opcode 1, A=2; done_evp 3 cycles after start_evp with res=32'd57, sts=0; out_ready=1 -> exactly one start_evp pulse, A_out=2, output words 57 then 0, instr_count=1.
- RST opcode 3 -> rst_instr low for exactly 1 cycle, no start_* pulse, output words 0, 0.
- Opcode 4'hA -> no start or rst_instr pulse, output words 0 then 32'h3.
- EVP followed by STP with out_ready held 0 for 5 cycles at WRITE_RES -> out_data holds its value while stalled, no second pop until status is accepted, both instructions complete in order.
- rst asserted during WAIT_DONE -> next cycle state IDLE, busy=0, out_valid=0, no output words; a stray done_evp afterwards is ignored.
- Macro defined, TIMEOUT_CYCLES=16, done never asserted -> rst_instr pulse after 16 cycles in WAIT_DONE, outputs 0 then 32'h4; macro undefined -> busy stays high indefinitely.
